str_sampler: RTL

Synchronous consumer for the self-timed ring: samples the free-running ring stage outputs `s[LEN-1:0]` on the system clock and extracts one raw bit per cycle as the XOR of all stages. The raw stream passes through an optional von Neumann corrector and a repetition-count health test. Corrected bits are packed into WORD_W-bit words and delivered over a valid/ready interface to the TRNG register/FIFO layer.

---
 rtl/str_sampler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/str_sampler.sv
// Clock-domain consumer for the self-timed ring: samples the stage outputs, extracts
// one parity bit per cycle, optionally debiases it, health-tests it and packs words.
module str_sampler #(
  parameter int LEN       = 8,
  parameter int WORD_W    = 32,
  parameter int VN_EN     = 1,
  parameter int RCT_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LEN-1:0]    s,
  input  logic              clr_flags,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              overrun,
  output logic              alarm
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RC_W  = $clog2(RCT_LIMIT + 1);

  logic [LEN-1:0]    r_s_q1, r_s_q2;
  logic              r_en_q1, r_en_q2;
  logic              r_vn_half, r_vn_b0;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic [RC_W-1:0]   r_rc;
  logic              r_last_raw;

  logic              w_raw, w_raw_vld;
  logic              w_bit, w_bit_vld;
  logic              w_accept, w_complete, w_load, w_ovr_set;
  logic [WORD_W-1:0] w_word;
  logic [RC_W-1:0]   w_rc_next;
  logic              w_alarm_set;

  // Raw bit extraction, debiasing, packing decisions and repetition-count update.
  always_comb begin
    w_raw     = ^r_s_q2;
    w_raw_vld = r_en_q2;
    w_bit     = w_raw;
    w_bit_vld = w_raw_vld;
    if (VN_EN != 0) begin
      w_bit     = r_vn_b0;
      w_bit_vld = w_raw_vld && r_vn_half && (w_raw != r_vn_b0);
    end else begin
      w_bit     = w_raw;
      w_bit_vld = w_raw_vld;
    end

    // A raised alarm freezes the packer; an already valid word still drains.
    w_accept   = w_bit_vld && !alarm;
    w_complete = w_accept && (r_cnt == CNT_W'(WORD_W - 1));
    w_word     = r_shift;
    w_word[r_cnt] = w_bit;
    w_load     = w_complete && (!valid || ready);
    w_ovr_set  = w_complete && valid && !ready;

    w_rc_next = '0;
    if (w_raw_vld) begin
      if (w_raw == r_last_raw) begin
        w_rc_next = (r_rc == RC_W'(RCT_LIMIT)) ? r_rc : r_rc + RC_W'(1);
      end else begin
        w_rc_next = RC_W'(1);
      end
    end else begin
      w_rc_next = '0;
    end
    w_alarm_set = w_raw_vld && (w_rc_next == RC_W'(RCT_LIMIT));
  end

  // Synchroniser, corrector state, packer, health counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q1     <= '0;
      r_s_q2     <= '0;
      r_en_q1    <= 1'b0;
      r_en_q2    <= 1'b0;
      r_vn_half  <= 1'b0;
      r_vn_b0    <= 1'b0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rc       <= '0;
      r_last_raw <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      r_s_q1  <= s;
      r_s_q2  <= r_s_q1;
      r_en_q1 <= en;
      r_en_q2 <= r_en_q1;

      if (w_raw_vld) begin
        if (!r_vn_half) begin
          r_vn_b0 <= w_raw;
        end
        r_vn_half <= !r_vn_half;
      end else begin
        r_vn_half <= 1'b0;
      end

      if (w_accept) begin
        r_shift[r_cnt] <= w_bit;
        r_cnt <= w_complete ? '0 : r_cnt + CNT_W'(1);
      end

      if (w_raw_vld) begin
        r_last_raw <= w_raw;
      end
      r_rc <= clr_flags ? '0 : w_rc_next;

      if (w_load) begin
        data  <= w_word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (w_ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end

      if (w_alarm_set) begin
        alarm <= 1'b1;
      end else if (clr_flags) begin
        alarm <= 1'b0;
      end
    end
  end

endmodule
